fsm_vector_sequencer: RTL

//   Sequences one benchmark control FSM (13 inputs x1..x13, 20 outputs y1..y20, e.g. e8)

---
 rtl/fsm_seq_pkg.sv | 25 ++
 rtl/fsm_vec_mem.sv | 28 ++
 rtl/fsm_vector_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the FSM vector sequencer.
package fsm_seq_pkg;

  localparam int IN_W_DEF   = 13;
  localparam int OUT_W_DEF  = 20;
  localparam int DEPTH_DEF  = 32;
  localparam int SETTLE_DEF = 2;

  localparam logic [7:0] CNT_MAX = 8'd255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRST,
    S_APPLY,
    S_SAMPLE,
    S_STEP,
    S_FIN
  } state_t;

  // Increment that sticks at CNT_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fsm_vec_mem.sv
// Stimulus/golden entry store: one write port, one asynchronous read port.
module fsm_vec_mem #(
  parameter int IN_W   = 13,
  parameter int OUT_W  = 20,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [IN_W-1:0]   wstim,
  input  logic [OUT_W-1:0]  wgold,
  input  logic [ADDR_W-1:0] raddr,
  output logic [IN_W-1:0]   rstim,
  output logic [OUT_W-1:0]  rgold
);

  // Each word packs {golden, stimulus}; contents are deliberately not reset.
  logic [IN_W+OUT_W-1:0] mem_q [DEPTH];

  // Host write port.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= {wgold, wstim};
  end

  assign {rgold, rstim} = mem_q[raddr];

endmodule

// File: rtl/fsm_vector_sequencer.sv
// Drives an FSM-under-test through a stored run of input vectors and scores
// each masked output vector against its golden value.
module fsm_vector_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [IN_W-1:0]   cfg_stim,
  input  logic [OUT_W-1:0]  cfg_gold,
  input  logic [OUT_W-1:0]  cfg_mask,
  input  logic [ADDR_W:0]   run_len,
  input  logic              start,
  input  logic              abort,
  output logic              dut_rst,
  output logic              dut_step,
  output logic [IN_W-1:0]   dut_x,
  input  logic [OUT_W-1:0]  dut_y,
  output logic              busy,
  output logic              done,
  output logic [7:0]        mismatch_cnt,
  output logic              fail_flag,
  output logic [ADDR_W-1:0] first_fail_idx
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int SET_W = $clog2(SETTLE + 2);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [OUT_W-1:0]   mask_q, mask_d;
  logic [SET_W-1:0]   wait_q, wait_d;
  logic               dut_rst_q, dut_rst_d;
  logic               dut_step_q, dut_step_d;
  logic [IN_W-1:0]    dut_x_q, dut_x_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               fail_q, fail_d;
  logic [ADDR_W-1:0]  ffi_q, ffi_d;

  logic [IN_W-1:0]    rd_stim;
  logic [OUT_W-1:0]   rd_gold;
  logic [LEN_W-1:0]   start_len;
  logic               miss;

  // Reads follow the next index so dut_x picks up the new entry on APPLY entry.
  fsm_vec_mem #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (cfg_we && (state_q == S_IDLE)),
    .waddr(cfg_addr),
    .wstim(cfg_stim),
    .wgold(cfg_gold),
    .raddr(idx_d),
    .rstim(rd_stim),
    .rgold(rd_gold)
  );

  assign start_len = (run_len > DEPTH_L) ? DEPTH_L : run_len;
  assign miss      = |((dut_y ^ rd_gold) & mask_q);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mask_d  = mask_q;
    wait_d  = wait_q;
    dut_x_d = dut_x_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = start_len;
          mask_d  = cfg_mask;
          cnt_d   = '0;
          fail_d  = 1'b0;
          ffi_d   = '0;
          idx_d   = '0;
          wait_d  = SET_W'(1);
          state_d = (start_len == '0) ? S_FIN : S_DRST;
        end
      end
      S_DRST: begin
        if (wait_q == '0) begin
          state_d = S_APPLY;
          wait_d  = SET_W'(SETTLE - 1);
          dut_x_d = rd_stim;
        end else begin
          wait_d = wait_q - SET_W'(1);
        end
      end
      S_APPLY: begin
        if (wait_q == '0) state_d = S_SAMPLE;
        else              wait_d  = wait_q - SET_W'(1);
      end
      S_SAMPLE: begin
        if (miss) begin
          cnt_d  = sat_inc(cnt_q);
          fail_d = 1'b1;
          if (!fail_q) ffi_d = idx_q;
        end
        state_d = S_STEP;
      end
      S_STEP: begin
        if ({1'b0, idx_q} == len_q - LEN_W'(1)) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          wait_d  = SET_W'(SETTLE - 1);
          dut_x_d = rd_stim;
          state_d = S_APPLY;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort drops straight to IDLE and freezes whatever results exist.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      dut_x_d = dut_x_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      ffi_d   = ffi_q;
    end

    dut_rst_d  = !(state_d inside {S_APPLY, S_SAMPLE, S_STEP});
    busy_d     = state_d inside {S_DRST, S_APPLY, S_SAMPLE, S_STEP};
    done_d     = (state_d == S_FIN);
    dut_step_d = (state_d == S_STEP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      mask_q     <= '0;
      wait_q     <= '0;
      dut_rst_q  <= 1'b1;
      dut_step_q <= 1'b0;
      dut_x_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      fail_q     <= 1'b0;
      ffi_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      mask_q     <= mask_d;
      wait_q     <= wait_d;
      dut_rst_q  <= dut_rst_d;
      dut_step_q <= dut_step_d;
      dut_x_q    <= dut_x_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      ffi_q      <= ffi_d;
    end
  end

  assign dut_rst        = dut_rst_q;
  assign dut_step       = dut_step_q;
  assign dut_x          = dut_x_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch_cnt   = cnt_q;
  assign fail_flag      = fail_q;
  assign first_fail_idx = ffi_q;

endmodule
